// File: rtl/share_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | share_pipe_pkg                                                       |
// | Width helpers shared by the masked-share register pipeline.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package share_pipe_pkg;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int bus_width(input int shares, input int width);
        return shares * width;
    endfunction

    // Lowest bit of share s on the flattened share bus.
    function automatic int share_lo(input int s, input int width);
        return s * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/share_pipe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | share_pipe_stage                                                     |
// | One elastic register stage: data plus valid, ready chained upward.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module share_pipe_stage #(
    parameter int BUS_W = 2
) (
    input  logic             C,
    input  logic             R,
    input  logic             CLR,
    input  logic             vin,
    input  logic [BUS_W-1:0] din,
    input  logic             rdy_next,
    output logic             vout,
    output logic [BUS_W-1:0] dout,
    output logic             rdy
);

    logic             r_v;
    logic [BUS_W-1:0] r_data;

    assign rdy  = ~r_v | rdy_next;
    assign vout = r_v;
    assign dout = r_data;

    // Bubbles advance the valid bit only; data keeps its last word.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_v    <= 1'b0;
            r_data <= '0;
        end else if (CLR) begin
            r_v    <= 1'b0;
            r_data <= '0;
        end else if (rdy) begin
            r_v <= vin;
            if (vin) begin
                r_data <= din;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/share_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | share_pipe                                                           |
// | DEPTH-stage elastic pipeline for SHARES masked shares of WIDTH bits. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module share_pipe
    import share_pipe_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int SHARES = 2,
    parameter int DEPTH  = 2
) (
    input  logic                                C,
    input  logic                                R,
    input  logic                                CLR,
    input  logic                                IN_VALID,
    output logic                                IN_READY,
    input  logic [bus_width(SHARES, WIDTH)-1:0] D,
    output logic                                OUT_VALID,
    input  logic                                OUT_READY,
    output logic [bus_width(SHARES, WIDTH)-1:0] Q,
    output logic [occ_width(DEPTH)-1:0]         OCC
);

    localparam int                 c_bus_w   = bus_width(SHARES, WIDTH);
    localparam int                 c_occ_w   = occ_width(DEPTH);
    localparam logic [c_occ_w-1:0] c_occ_max = c_occ_w'(DEPTH);

    if (DEPTH < 1 || SHARES < 1 || WIDTH < 1) begin : g_param_check
        $error("share_pipe: DEPTH, SHARES and WIDTH must all be >= 1");
    end

    // Index 0 is the upstream side, index DEPTH is the downstream side.
    logic               w_v    [0:DEPTH];
    logic [c_bus_w-1:0] w_data [0:DEPTH];
    logic               w_rdy  [0:DEPTH];
    logic [DEPTH-1:0]   w_vbits;

    assign w_v[0]        = IN_VALID;
    assign w_data[0]     = D;
    assign w_rdy[DEPTH]  = OUT_READY;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        share_pipe_stage #(
            .BUS_W (c_bus_w)
        ) u_stage (
            .C        (C),
            .R        (R),
            .CLR      (CLR),
            .vin      (w_v[i]),
            .din      (w_data[i]),
            .rdy_next (w_rdy[i+1]),
            .vout     (w_v[i+1]),
            .dout     (w_data[i+1]),
            .rdy      (w_rdy[i])
        );
        assign w_vbits[i] = w_v[i+1];
    end

    assign IN_READY  = w_rdy[0];
    assign OUT_VALID = w_v[DEPTH];
    assign Q         = w_data[DEPTH];

    logic               w_accept;
    logic               w_emit;
    logic [c_occ_w-1:0] r_occ;

    assign w_accept = IN_VALID & w_rdy[0];
    assign w_emit   = w_v[DEPTH] & OUT_READY;
    assign OCC      = r_occ;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_occ <= '0;
        end else if (CLR) begin
            r_occ <= '0;
        end else if (w_accept && !w_emit && r_occ != c_occ_max) begin
            r_occ <= r_occ + c_occ_w'(1);
        end else if (w_emit && !w_accept && r_occ != '0) begin
            r_occ <= r_occ - c_occ_w'(1);
        end
    end

    a_occ_matches_valids: assert property (@(posedge C) disable iff (!R)
        int'(r_occ) == $countones(w_vbits));

endmodule
`default_nettype wire

// File: tb/tb_share_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_share_pipe                                                        |
// | Directed vectors and scoreboard for share_pipe at DEPTH 1..4.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_share_pipe;

    localparam int N_DUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] d;

    logic        in_ready_a  [N_DUT];
    logic        out_valid_a [N_DUT];
    logic [15:0] q_a         [N_DUT];
    logic [2:0]  occ_a       [N_DUT];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Instance k has DEPTH k+1; all share the same stimulus.
    for (genvar k = 0; k < N_DUT; k++) begin : g_dut
        localparam int DP = k + 1;
        logic [$clog2(DP+1)-1:0] occ_w;
        logic                    ir_w;
        logic                    ov_w;
        logic [15:0]             q_w;
        share_pipe #(
            .WIDTH  (8),
            .SHARES (2),
            .DEPTH  (DP)
        ) u_dut (
            .C         (clk),
            .R         (rst_n),
            .CLR       (clr),
            .IN_VALID  (in_valid),
            .IN_READY  (ir_w),
            .D         (d),
            .OUT_VALID (ov_w),
            .OUT_READY (out_ready),
            .Q         (q_w),
            .OCC       (occ_w)
        );
        assign in_ready_a[k]  = ir_w;
        assign out_valid_a[k] = ov_w;
        assign q_a[k]         = q_w;
        assign occ_a[k]       = 3'(occ_w);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        iv, ordy, cl;
        logic [15:0] din;
        logic        e_ir, e_ov;
        logic [15:0] e_q;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t        tbl [13];
    logic [15:0] sb [N_DUT][$];
    int          stall [N_DUT];

    initial begin
        int          exp_ov [7];
        int          exp_occ [7];
        logic [15:0] words [3];

        // DEPTH=2 sequence: fill/full, accept+emit when full, bubbles, flush.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'hABCD, 1'b1, 1'b0, 16'h0000, 3'd1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b1, 16'h1234, 3'd2};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 16'h00FF, 1'b1, 1'b1, 16'h1234, 3'd2};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hABCD, 3'd2};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h00FF, 3'd1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h0011, 1'b1, 1'b0, 16'h00FF, 3'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0022, 1'b1, 1'b0, 16'h00FF, 3'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'h0033, 1'b1, 1'b1, 16'h0011, 3'd1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0044, 1'b1, 1'b0, 16'h0011, 3'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0033, 3'd1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 16'h0055, 1'b1, 1'b1, 16'h0033, 3'd1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0};

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;
        @(negedge clk);
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            chk($sformatf("rst_ov[%0d]", k), out_valid_a[k], 0);
            chk($sformatf("rst_q[%0d]", k),  q_a[k], 0);
            chk($sformatf("rst_occ[%0d]", k), occ_a[k], 0);
            chk($sformatf("rst_ir[%0d]", k), in_ready_a[k], 1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy; clr = tbl[i].cl; d = tbl[i].din;
            #1;
            chk($sformatf("tbl%0d_ir", i),  in_ready_a[1],  tbl[i].e_ir);
            chk($sformatf("tbl%0d_ov", i),  out_valid_a[1], tbl[i].e_ov);
            chk($sformatf("tbl%0d_q", i),   q_a[1],         tbl[i].e_q);
            chk($sformatf("tbl%0d_occ", i), occ_a[1],       tbl[i].e_occ);
        end

        // Asynchronous reset in the middle of a cycle with DEPTH=2 full.
        do_reset();
        @(negedge clk); in_valid = 1'b1; d = 16'hA1A1;
        @(negedge clk); d = 16'hB2B2;
        @(negedge clk); in_valid = 1'b0;
        #1;
        chk("mid_full_occ", occ_a[1], 2);
        chk("mid_full_ir", in_ready_a[1], 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", out_valid_a[1], 0);
        chk("mid_rst_q", q_a[1], 0);
        chk("mid_rst_occ", occ_a[1], 0);
        chk("mid_rst_ir", in_ready_a[1], 1);
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b1; d = 16'h5A5A;
        #1;
        chk("rel_ir", in_ready_a[1], 1);
        @(negedge clk); in_valid = 1'b0;
        #1;
        chk("rel_occ", occ_a[1], 1);
        @(negedge clk);
        #1;
        chk("rel_ov", out_valid_a[1], 1);
        chk("rel_q", q_a[1], 16'h5A5A);

        // Streaming through DEPTH=3 with the output always ready.
        do_reset();
        out_ready = 1'b1;
        words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h00FF;
        exp_ov  = '{0, 0, 0, 1, 1, 1, 0};
        exp_occ = '{0, 1, 2, 3, 2, 1, 0};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            in_valid = (c < 3);
            d = (c < 3) ? words[c] : 16'h0000;
            #1;
            chk($sformatf("str%0d_ov", c), out_valid_a[2], exp_ov[c]);
            chk($sformatf("str%0d_occ", c), occ_a[2], exp_occ[c]);
            if (c >= 3 && c <= 5) chk($sformatf("str%0d_q", c), q_a[2], words[c-3]);
        end

        // Flush at OCC=2 with a simultaneous accept and emit.
        do_reset();
        @(negedge clk); in_valid = 1'b1; d = 16'hC1C1;
        @(negedge clk); d = 16'hD2D2;
        @(negedge clk); in_valid = 1'b1; d = 16'hE3E3; out_ready = 1'b1; clr = 1'b1;
        #1;
        chk("fl_pre_occ", occ_a[1], 2);
        chk("fl_pre_ov", out_valid_a[1], 1);
        chk("fl_pre_q", q_a[1], 16'hC1C1);
        @(negedge clk); clr = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_occ", occ_a[1], 0);
        chk("fl_ov", out_valid_a[1], 0);
        chk("fl_q", q_a[1], 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("fl_after%0d_ov", c), out_valid_a[1], 0);
        end

        // Random traffic against an in-order queue per instance.
        do_reset();
        for (int k = 0; k < N_DUT; k++) begin
            sb[k].delete();
            stall[k] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic        acc [N_DUT];
            logic        emt [N_DUT];
            logic        cl_s;
            logic [15:0] d_s;
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 63) == 0);
            d         = 16'($urandom);
            #1;
            for (int k = 0; k < N_DUT; k++) begin
                chk($sformatf("rnd_ir[%0d]", k), in_ready_a[k],
                    out_ready | (sb[k].size() < k + 1));
                chk($sformatf("rnd_occ[%0d]", k), occ_a[k], sb[k].size());
                if (out_valid_a[k]) begin
                    if (sb[k].size() == 0) chk($sformatf("rnd_spurious[%0d]", k), 1, 0);
                    else chk($sformatf("rnd_q[%0d]", k), q_a[k], sb[k][0]);
                end
                stall[k] = (sb[k].size() > 0 && !out_valid_a[k]) ? stall[k] + 1 : 0;
                chk($sformatf("rnd_latency[%0d]", k), (stall[k] > k + 1) ? 1 : 0, 0);
                acc[k] = in_valid & in_ready_a[k];
                emt[k] = out_valid_a[k] & out_ready;
            end
            cl_s = clr;
            d_s  = d;
            @(posedge clk);
            for (int k = 0; k < N_DUT; k++) begin
                if (emt[k] && sb[k].size() > 0) void'(sb[k].pop_front());
                if (cl_s) sb[k].delete();
                else if (acc[k]) sb[k].push_back(d_s);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/share_pipe.md
Name: share_pipe

Overview:
- Parametrised successor to the single-bit reset flop (DFFR): a DEPTH-stage elastic register pipeline carrying SHARES masked shares of WIDTH bits each.
- Adds per-stage valid tracking, valid/ready backpressure with bubble collapsing, a synchronous flush and an occupancy count.
- Sits between masked gadget layers; it is the standard register boundary for share-domain datapaths.

Parameters:
- WIDTH, 1, bits per share.
- SHARES, 2, number of shares per word (>=1).
- DEPTH, 2, number of register stages (>=1; 0 is illegal and must fail elaboration).

Ports:
- C  input  1  clock, rising edge.
- R  input  1  reset, asynchronous, active-low.
- CLR  input  1  synchronous flush, active-high.
- IN_VALID  input  1  upstream word valid.
- IN_READY  output  1  pipeline accepts a word this cycle.
- D  input  SHARES*WIDTH  input shares; share s occupies bits [s*WIDTH +: WIDTH].
- OUT_VALID  output  1  stage DEPTH-1 holds a valid word.
- OUT_READY  input  1  downstream consumes the word this cycle.
- Q  output  SHARES*WIDTH  data of stage DEPTH-1, registered, no combinational logic after the flop.
- OCC  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Per stage i, state is data_i[SHARES*WIDTH] and v_i[1].
- Reset (R=0, asynchronous): all data_i = 0, all v_i = 0, OCC = 0. Outputs therefore reset to OUT_VALID=0, Q=0, IN_READY=1, OCC=0.
- Release of R takes effect on the next rising edge of C.
- Stage ready chain:
  - rdy_DEPTH = OUT_READY.
  - rdy_i = !v_i | rdy_{i+1}.
  - IN_READY = rdy_0.
  - This gives a combinational path OUT_READY -> IN_READY. There is no combinational path from IN_VALID or D to any output.
- Stage update on a rising edge, when rdy_i = 1:
  - v_i <= v_{i-1}, with v_{-1} = IN_VALID.
  - data_i <= data_{i-1} only when v_{i-1} = 1. Data registers do not load bubbles: they hold their old value. Shares are never recombined or XORed.
- When rdy_i = 0, the stage holds both data_i and v_i.
- Transfers:
  - Accept occurs when IN_VALID & IN_READY.
  - Emit occurs when OUT_VALID & OUT_READY.
- Latency: an accepted word appears at Q exactly DEPTH cycles after acceptance if no stall occurs. Throughput is 1 word/cycle with OUT_READY held at 1.
- Bubble collapsing: a stalled output lets upstream stages fill, so up to DEPTH words are held.
- Full: all v_i = 1 and OUT_READY = 0 -> IN_READY = 0. When full with OUT_READY = 1 -> IN_READY = 1, and simultaneous accept and emit keeps OCC unchanged.
- Empty: all v_i = 0 -> OUT_VALID = 0. IN_READY = 1 regardless of OUT_READY.
- OCC:
  - Registered counter.
  - +1 on accept only, -1 on emit only, unchanged on both or neither.
  - Saturates: never exceeds DEPTH and never wraps below 0. Assert OCC == popcount(v).
- CLR = 1 at an edge:
  - All v_i <= 0, all data_i <= 0, OCC <= 0.
  - An accept in that same cycle is discarded, and an emit in that same cycle still counts as delivered to downstream.
  - CLR has priority over all updates.
- Reset mid-operation: asynchronous clear as above. In-flight words are lost, and no partial word is ever emitted.

Decomposition:
- Package share_pipe_pkg:
  - Function occ_width(depth) = $clog2(depth+1).
  - Localparam-style helper for the SHARES*WIDTH bus width.
  - Share slice index function share_lo(s, width).
- Sub-module share_pipe_stage:
  - One stage holding data + valid.
  - Inputs: C, R, CLR, vin, din, rdy_next.
  - Outputs: vout, dout, rdy.
- The top level instantiates DEPTH stages in a generate loop and owns the OCC counter.

Test Plan:
- Reset/idle: assert R=0 mid-cycle with DEPTH=2 holding 2 words -> immediately OUT_VALID=0, Q=0, OCC=0, IN_READY=1. Release R -> first accept on the following edge.
- Streaming, DEPTH=3, SHARES=2, WIDTH=8, OUT_READY=1: send D=0x1234, 0xABCD, 0x00FF on consecutive cycles -> Q shows the same values in order on cycles 3, 4, 5 after the first accept. OCC steady at 3 during overlap.
- Backpressure/full, DEPTH=2: hold OUT_READY=0 and send 3 words -> IN_READY drops after 2 accepts, OCC=2. Raise OUT_READY -> 3rd word accepted in the same cycle as the first emit, OCC stays 2. No word is lost or duplicated.
- Bubbles: IN_VALID pattern 1,0,1,0 with D=0x11,0x22,0x33,0x44 -> only 0x11 and 0x33 emitted. Stage data registers hold through bubbles, and Q is unchanged while OUT_VALID=0.
- Flush: OCC=2, CLR=1 with IN_VALID=1 and OUT_READY=1 in the same cycle -> next cycle OCC=0, OUT_VALID=0, Q=0. The incoming word is never emitted.
- Randomised scoreboard: random IN_VALID/OUT_READY/CLR over 10k cycles with DEPTH=1 and DEPTH=4 -> in-order exact data match, OCC == popcount(v), IN_READY matches the ready chain every cycle.
